stepdir_decoder: RTL

- Receiver end of the step/dir interface: samples external step and dir lines, accumulates a signed position count, and checks the stream against the configured step-width and dir-setup timings.
- Used for loopback verification of the on-chip step generator and for counting step/dir commands fed in from an external controller.
- Sits in the same clock domain as the step generator, programmed with the same dirtime/steptime values.

---
 rtl/stepdir_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stepdir_decoder.sv
// Step/dir receiver: synchronizes step and dir, keeps a signed position count, checks step-width and dir-setup/hold timing.
// Latency: step_strobe and the position update appear SYNC+1 clk cycles after a raw step rise.
// Backpressure: none; every synchronized rising edge is consumed (or dropped when disabled/cleared) in the cycle it is seen.
//
// Ports:
//   clk, rst_n          system clock (rising edge), asynchronous active-low reset
//   enable              count/check enable; when low the FSM only tracks the step level
//   step, dir           raw asynchronous step/dir lines; dir=1 decrements
//   steptime, dirtime   minimum step-high width and dir-setup time in clk cycles (0 disables the check)
//   clear, err_clr      synchronous zeroing of position / of the sticky error flags
//   position            accumulated W-bit two's-complement step count (wraps)
//   step_strobe         one-cycle pulse per counted step
//   setup_err, hold_err, width_err   sticky timing error flags
module stepdir_decoder #(
    parameter int W    = 22,
    parameter int T    = 5,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         step,
    input  logic         dir,
    input  logic [T-1:0] steptime,
    input  logic [T-1:0] dirtime,
    input  logic         clear,
    input  logic         err_clr,
    output logic [W-1:0] position,
    output logic         step_strobe,
    output logic         setup_err,
    output logic         hold_err,
    output logic         width_err
);

    localparam logic [0:0]   ST_LOW  = 1'b0;
    localparam logic [0:0]   ST_HIGH = 1'b1;
    localparam logic [T-1:0] CNT_MAX = '1;

    // Synchronizer chains; the top bit is the usable synchronized level.
    logic [SYNC-1:0] step_sync_q;
    logic [SYNC-1:0] dir_sync_q;
    logic            ss;
    logic            sd;
    logic            ss_dly_q;
    logic            sd_dly_q;

    logic            ss_rise;
    logic            ss_fall;
    logic            sd_chg;

    logic [0:0]      state_q,    state_d;
    logic [T-1:0]    high_cnt_q, high_cnt_d;
    logic [T-1:0]    dir_age_q,  dir_age_d;
    logic [T-1:0]    dir_age_now;
    logic [W-1:0]    position_q, position_d;
    logic            strobe_q,   strobe_d;
    logic            setup_q,    setup_d;
    logic            hold_q,     hold_d;
    logic            width_q,    width_d;
    logic            set_setup;
    logic            set_hold;
    logic            set_width;

    assign ss      = step_sync_q[SYNC-1];
    assign sd      = dir_sync_q[SYNC-1];
    assign ss_rise = ss & ~ss_dly_q;
    assign ss_fall = ~ss & ss_dly_q;
    assign sd_chg  = sd ^ sd_dly_q;

    // A dir change seen in the same cycle as the step rise means zero
    // cycles of setup, even though the registered age has not yet reset.
    assign dir_age_now = sd_chg ? '0 : dir_age_q;

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        position_d = position_q;
        strobe_d   = 1'b0;
        set_setup  = 1'b0;
        set_hold   = 1'b0;
        set_width  = 1'b0;

        // Dir age runs independently of enable so setup is judged
        // correctly on the first step after enable rises.
        if (sd_chg) begin
            dir_age_d = '0;
        end else if (dir_age_q == CNT_MAX) begin
            dir_age_d = dir_age_q;
        end else begin
            dir_age_d = dir_age_q + T'(1);
        end

        if (enable) begin
            case (state_q)
                ST_LOW: begin
                    if (ss_rise) begin
                        state_d    = ST_HIGH;
                        strobe_d   = 1'b1;
                        high_cnt_d = T'(1);
                        position_d = sd ? (position_q - W'(1)) : (position_q + W'(1));
                        if ((dirtime != '0) && (dir_age_now < dirtime)) begin
                            set_setup = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (ss_fall) begin
                        state_d = ST_LOW;
                        if ((steptime != '0) && (high_cnt_q < steptime)) begin
                            set_width = 1'b1;
                        end
                    end else begin
                        if (high_cnt_q != CNT_MAX) begin
                            high_cnt_d = high_cnt_q + T'(1);
                        end
                        if (sd_chg) begin
                            set_hold = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOW;
                end
            endcase
        end else begin
            // Track the level only, so a step already high at re-enable
            // is not mistaken for a fresh rising edge.
            state_d = ss ? ST_HIGH : ST_LOW;
        end

        // Clear overrides any count from a coinciding edge; the strobe
        // above is deliberately left intact.
        if (clear) begin
            position_d = '0;
        end

        // A newly detected error wins over a simultaneous err_clr.
        setup_d = (setup_q & ~err_clr) | set_setup;
        hold_d  = (hold_q  & ~err_clr) | set_hold;
        width_d = (width_q & ~err_clr) | set_width;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            ss_dly_q    <= 1'b0;
            sd_dly_q    <= 1'b0;
            state_q     <= ST_LOW;
            high_cnt_q  <= '0;
            dir_age_q   <= CNT_MAX;
            position_q  <= '0;
            strobe_q    <= 1'b0;
            setup_q     <= 1'b0;
            hold_q      <= 1'b0;
            width_q     <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC-2:0], step};
            dir_sync_q  <= {dir_sync_q[SYNC-2:0], dir};
            ss_dly_q    <= ss;
            sd_dly_q    <= sd;
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            dir_age_q   <= dir_age_d;
            position_q  <= position_d;
            strobe_q    <= strobe_d;
            setup_q     <= setup_d;
            hold_q      <= hold_d;
            width_q     <= width_d;
        end
    end

    assign position    = position_q;
    assign step_strobe = strobe_q;
    assign setup_err   = setup_q;
    assign hold_err    = hold_q;
    assign width_err   = width_q;

endmodule
